// File: rtl/comb_seq_pkg.sv
// comb_seq_pkg: shared FSM state type, sizing constants and result helpers
// for the combinational truth-table sequencer.
package comb_seq_pkg;

    localparam int VEC_CNT = 8;            // number of input vectors {A,B,C}
    localparam int IDX_W   = 3;            // width of the vector index
    localparam int TMR_W   = 4;            // settle timer width
    localparam int CNT_W   = 4;            // mismatch count width (0..8)
    localparam logic [VEC_CNT-1:0] EXP_MASK_DEF = 8'hB4;  // minterms 2,4,5,7

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } seq_state_e;

    // Number of set bits in a table-sized vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_CNT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_CNT; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit, 0 when no bit is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [VEC_CNT-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = VEC_CNT - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/comb_seq_settle_timer.sv
// comb_seq_settle_timer: down-counter that times how long each vector is
// held. load_i presets the count; while count_i is high it decrements and
// expire_o flags the final cycle of the wait.
module comb_seq_settle_timer
    import comb_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             count_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] cnt_q;

    // Preset on load, otherwise count down to zero while counting is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = count_i && (cnt_q == '0);

endmodule

// File: rtl/comb_truth_table_sequencer.sv
// comb_truth_table_sequencer: sweeps {A,B,C} through 0..7, holds each vector
// SETTLE_CYC cycles, samples Y in one extra cycle and compares the captured
// table against EXP_MASK.
// Optional feature: define TT_SEQ_ABORT_EN to add the abort input.
module comb_truth_table_sequencer
    import comb_seq_pkg::*;
#(
    parameter int unsigned         SETTLE_CYC = 2,
    parameter logic [VEC_CNT-1:0]  EXP_MASK   = EXP_MASK_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               y_in,
`ifdef TT_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [IDX_W-1:0]   abc,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [VEC_CNT-1:0] table_out,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [IDX_W-1:0]   first_fail_idx
);

    // Timer preset gives exactly SETTLE_CYC DRIVE cycles (counts down to 0).
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_CNT - 1);

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VEC_CNT-1:0] table_q, table_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic [IDX_W-1:0]   ffi_q, ffi_d;
    logic [VEC_CNT-1:0] diff;
    logic               tmr_load, tmr_count, tmr_expire;

    comb_seq_settle_timer u_settle (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LD),
        .count_i    (tmr_count),
        .expire_o   (tmr_expire)
    );

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            mcnt_q  <= '0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            mcnt_q  <= mcnt_d;
            ffi_q   <= ffi_d;
        end
    end

    // Next-state: sweep sequencing, sampling, and verdict on the last sample.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        table_d   = table_q;
        pass_d    = pass_q;
        mcnt_d    = mcnt_q;
        ffi_d     = ffi_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        diff      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = '0;
                    table_d  = '0;
                    pass_d   = 1'b0;
                    mcnt_d   = '0;
                    ffi_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            DRIVE: begin
                tmr_count = 1'b1;
                if (tmr_expire) state_d = SAMPLE;
            end
            SAMPLE: begin
                table_d[idx_q] = y_in;
                if (idx_q == LAST_IDX) begin
                    // Verdict is registered here so it is valid during DONE.
                    state_d = DONE;
                    diff    = table_d ^ EXP_MASK;
                    pass_d  = (diff == '0);
                    mcnt_d  = popcount(diff);
                    ffi_d   = lowest_set(diff);
                end else begin
                    state_d  = DRIVE;
                    idx_d    = idx_q + 1'b1;
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef TT_SEQ_ABORT_EN
        // Abort wins over any sample write; partial table bits are kept.
        if (abort && ((state_q == DRIVE) || (state_q == SAMPLE))) begin
            state_d   = IDLE;
            idx_d     = idx_q;
            table_d   = table_q;
            pass_d    = 1'b0;
            mcnt_d    = mcnt_q;
            ffi_d     = ffi_q;
            tmr_load  = 1'b0;
            tmr_count = 1'b0;
        end
`endif
    end

    // abc tracks idx, which is only changed at accept and between vectors.
    assign abc            = idx_q;
    assign busy           = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign table_out      = table_q;
    assign mismatch_cnt   = mcnt_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_comb_truth_table_sequencer.sv
// Bench for comb_truth_table_sequencer. The function under test is modelled
// as an 8-entry lookup (fut_mask); expected verdicts come from the XOR of
// that table with 8'hB4. Cycle 1 is the first cycle after the accept edge.
module tb_comb_truth_table_sequencer;

    localparam int SC      = 2;
    localparam int LAT     = 8 * (SC + 1) + 1;
    localparam logic [7:0] EXPM = 8'hB4;

    logic       clk = 1'b0;
    logic       rst, start, y_in;
    logic       abort;
    logic [2:0] abc;
    logic       busy, done, pass;
    logic [7:0] table_out;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail_idx;

    logic [7:0] fut_mask;
    logic       y_ovr_en, y_ovr;

    int checks   = 0;
    int failures = 0;

    comb_truth_table_sequencer #(.SETTLE_CYC(SC), .EXP_MASK(EXPM)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .y_in           (y_in),
`ifdef TT_SEQ_ABORT_EN
        .abort          (abort),
`endif
        .abc            (abc),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .table_out      (table_out),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx)
    );

    always #5 clk = ~clk;

    // Function under test: table lookup on abc, or a forced value.
    always_comb y_in = y_ovr_en ? y_ovr : fut_mask[abc];

    function automatic int ref_cnt(input logic [7:0] t);
        return $countones(t ^ EXPM);
    endfunction

    function automatic int ref_ffi(input logic [7:0] t);
        logic [7:0] d;
        d = t ^ EXPM;
        for (int i = 0; i < 8; i++) if (d[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start from IDLE, then run up to 45 cycles; optional re-pulses.
    task automatic run_sweep(input int ra, input int rb, output int lat, output int nd);
        lat = 0;
        nd  = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 45; c++) begin
            start = (c == ra) || (c == rb);
            if (done) begin
                nd++;
                if (lat == 0) lat = c;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; y_ovr_en = 1'b0; y_ovr = 1'b0;
        fut_mask = EXPM;
        #3;
        checks++;
        if ({abc, busy, done, pass, table_out, mismatch_cnt, first_fail_idx} !== '0) begin
            failures++;
            $display("FAIL reset_state got abc=%0d busy=%0b done=%0b pass=%0b tbl=%h cnt=%0d ffi=%0d want all 0",
                     abc, busy, done, pass, table_out, mismatch_cnt, first_fail_idx);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_reset busy=%0b want 0", busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL first_edge_accept busy=%0b want 1", busy);
        end
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) tick();
        checks++;
        if (done !== 1'b1 || table_out !== EXPM) begin
            failures++;
            $display("FAIL first_sweep done=%0b tbl=%h want 1 %h", done, table_out, EXPM);
        end
        tick();
    endtask

    task automatic test_sweep(input string name, input logic [7:0] fut);
        int lat, nd;
        fut_mask = fut;
        run_sweep(0, 0, lat, nd);
        checks++;
        if (lat !== LAT || nd !== 1) begin
            failures++;
            $display("FAIL %s_latency got lat=%0d dones=%0d want %0d 1", name, lat, nd, LAT);
        end
        checks++;
        if (table_out !== fut) begin
            failures++;
            $display("FAIL %s_table got %h want %h", name, table_out, fut);
        end
        checks++;
        if (pass !== (fut == EXPM)) begin
            failures++;
            $display("FAIL %s_pass got %0b want %0b", name, pass, fut == EXPM);
        end
        checks++;
        if (int'(mismatch_cnt) !== ref_cnt(fut) || int'(first_fail_idx) !== ref_ffi(fut)) begin
            failures++;
            $display("FAIL %s_mismatch got cnt=%0d ffi=%0d want %0d %0d",
                     name, mismatch_cnt, first_fail_idx, ref_cnt(fut), ref_ffi(fut));
        end
    endtask

    task automatic test_random();
        logic [7:0] f;
        for (int i = 0; i < 6; i++) begin
            f = 8'($urandom);
            test_sweep("random", f);
        end
    endtask

    task automatic test_hold();
        logic [7:0] f;
        f = 8'h3C;
        test_sweep("hold_pre", f);
        fut_mask = 8'h00;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (table_out !== f || int'(mismatch_cnt) !== ref_cnt(f) || busy !== 1'b0) begin
            failures++;
            $display("FAIL result_hold tbl=%h cnt=%0d busy=%0b want %h %0d 0",
                     table_out, mismatch_cnt, busy, f, ref_cnt(f));
        end
    endtask

    task automatic test_restart_ignored();
        int lat, nd;
        fut_mask = EXPM;
        run_sweep(5, 12, lat, nd);
        checks++;
        if (lat !== LAT || nd !== 1) begin
            failures++;
            $display("FAIL restart_ignored got lat=%0d dones=%0d want %0d 1", lat, nd, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, nd, k;
        d1 = 0; d2 = 0; nd = 0;
        fut_mask = EXPM;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done) begin
                nd++;
                if (nd == 1) d1 = c;
                else if (nd == 2) d2 = c;
            end
        end
        start = 1'b0;
        checks++;
        if (nd !== 2 || (d2 - d1) !== 26) begin
            failures++;
            $display("FAIL back_to_back got dones=%0d spacing=%0d want 2 26", nd, d2 - d1);
        end
        k = 0;
        while ((busy || done) && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (busy || done) begin
            failures++;
            $display("FAIL b2b_drain still busy=%0b done=%0b want idle", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        fut_mask = EXPM;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 13; c++) tick();
        checks++;
        if (abc !== 3'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset abc=%0d busy=%0b want 4 1", abc, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({abc, busy, done, pass, table_out, mismatch_cnt, first_fail_idx} !== '0) begin
            failures++;
            $display("FAIL mid_reset abc=%0d busy=%0b done=%0b pass=%0b tbl=%h cnt=%0d ffi=%0d want all 0",
                     abc, busy, done, pass, table_out, mismatch_cnt, first_fail_idx);
        end
        tick(); tick();
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) nd++;
            tick();
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_done got %0d dones want 0", nd);
        end
        test_sweep("post_reset", EXPM);
    endtask

    task automatic test_abc_seq();
        logic [7:0] f;
        int v, p;
        f = 8'($urandom);
        fut_mask = f;
        y_ovr_en = 1'b1;
        y_ovr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8 * (SC + 1); c++) begin
            v = (c - 1) / (SC + 1);
            p = (c - 1) % (SC + 1);
            // Correct Y only in the sampling cycle, inverted while settling.
            y_ovr = (p == SC) ? f[v] : ~f[v];
            checks++;
            if (int'(abc) !== v || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL abc_seq cycle=%0d abc=%0d busy=%0b done=%0b want %0d 1 0",
                         c, abc, busy, done, v);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || table_out !== f || abc !== 3'd7) begin
            failures++;
            $display("FAIL abc_seq_done done=%0b busy=%0b tbl=%h abc=%0d want 1 0 %h 7",
                     done, busy, table_out, abc, f);
        end
        tick();
        checks++;
        if (abc !== 3'd7 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abc_hold abc=%0d busy=%0b done=%0b want 7 0 0", abc, busy, done);
        end
        y_ovr_en = 1'b0;
    endtask

`ifdef TT_SEQ_ABORT_EN
    task automatic test_abort();
        int nd, k;
        fut_mask = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        checks++;
        if (abc !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre abc=%0d busy=%0b want 3 1", abc, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || table_out !== 8'h07 || pass !== 1'b0) begin
            failures++;
            $display("FAIL abort_sample busy=%0b done=%0b tbl=%h pass=%0b want 0 0 07 0",
                     busy, done, table_out, pass);
        end
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) nd++;
            tick();
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d dones want 0", nd);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_idle busy=%0b want 1", busy);
        end
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (done !== 1'b1 || table_out !== 8'hFF) begin
            failures++;
            $display("FAIL abort_recover done=%0b tbl=%h want 1 ff", done, table_out);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_sweep("nand_ref", EXPM);
        test_sweep("stuck0", 8'h00);
        test_sweep("all_wrong", ~EXPM);
        test_random();
        test_hold();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_abc_seq();
`ifdef TT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comb_truth_table_sequencer.md
COMB_TRUTH_TABLE_SEQUENCER -- requirements
Module: comb_truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, which is the number of cycles each input vector is held before sampling (legal range 1..15).
REQ-002 The block SHALL have parameter EXP_MASK, default 8'hB4, which is the expected truth table (bit i = Y for {A,B,C}=i; minterms 2,4,5,7).
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have a port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have a port start, input, 1 bit: request to run one full sweep.
REQ-006 The block SHALL have a port y_in, input, 1 bit: the Y output of the combinational function under test.
REQ-007 The block SHALL have a port abc, output, 3 bits: the vector driven to the function; abc[2]=A, abc[1]=B, abc[0]=C.
REQ-008 The block SHALL have a port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have a port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-010 The block SHALL have a port pass, output, 1 bit: captured table equals EXP_MASK.
REQ-011 The block SHALL have a port table_out, output, 8 bits: captured truth table.
REQ-012 The block SHALL have a port mismatch_cnt, output, 4 bits: number of bits where table_out differs from EXP_MASK (0..8).
REQ-013 The block SHALL have a port first_fail_idx, output, 3 bits: the lowest mismatching index, or 0 when there is none.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 In IDLE with start=1, the FSM SHALL go to DRIVE at the next edge, set idx=0, clear table_out, and set busy=1.
REQ-016 start SHALL be ignored in DRIVE, SAMPLE and DONE, and SHALL NOT restart or extend a sweep.
REQ-017 abc SHALL equal idx in every cycle of DRIVE and SAMPLE, and SHALL be held at its last value otherwise.
REQ-018 DRIVE SHALL last exactly SETTLE_CYC cycles per vector, counted by the settle timer, and then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and SHALL write y_in into table_out[idx].
REQ-020 After SAMPLE, the FSM SHALL go to DONE if idx==7; otherwise it SHALL increment idx and go to DRIVE.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0; pass, mismatch_cnt and first_fail_idx SHALL become valid in that cycle; the FSM then goes to IDLE.
REQ-022 Latency from the start-accept edge to done=1 SHALL be 8*(SETTLE_CYC+1)+1 cycles, i.e. 25 cycles at default.
REQ-023 pass, mismatch_cnt, first_fail_idx and table_out SHALL hold until the next accepted start.
REQ-024 At an accepted start, pass, mismatch_cnt and first_fail_idx SHALL clear to 0.
REQ-025 mismatch_cnt SHALL be the popcount of table_out XOR EXP_MASK, and SHALL be 4 bits wide with no overflow (max 8).
REQ-026 start held high continuously SHALL produce back-to-back sweeps, with each new sweep accepted in the IDLE cycle following DONE.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, idx=0, abc=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0, first_fail_idx=0, and the settle counter to 0.
REQ-028 Reset during a sweep SHALL discard the partial results and SHALL NOT generate a done pulse.
REQ-029 The first start SHALL be accepted no earlier than the first rising edge after rst deasserts.

Configuration
REQ-030 With TT_SEQ_ABORT_EN defined, the block SHALL add an input port abort (1 bit, active-high).
REQ-031 With TT_SEQ_ABORT_EN defined, abort=1 in DRIVE or SAMPLE SHALL move the FSM to IDLE at the next edge with busy=0, no done pulse, table_out retaining its partially captured bits, and pass=0.
REQ-032 With TT_SEQ_ABORT_EN defined, abort SHALL have no effect in IDLE or DONE, and abort SHALL take priority over a SAMPLE write in the same cycle.
REQ-033 Without TT_SEQ_ABORT_EN, there SHALL be no abort port and no abort logic.

Structure
REQ-034 Package comb_seq_pkg SHALL hold the FSM state typedef, VEC_CNT=8, IDX_W=3, and the default EXP_MASK constant 8'hB4.
REQ-035 The settle wait counter SHALL be a sub-module named comb_seq_settle_timer, with load/count/expire signals and width 4.

Verification
REQ-036 A bench SHALL check: reference NAND function as DUT, SETTLE_CYC=2, start pulsed once -> done exactly 25 cycles later, table_out=8'hB4, pass=1, mismatch_cnt=0, first_fail_idx=0.
REQ-037 A bench SHALL check: y_in stuck at 0 -> table_out=8'h00, pass=0, mismatch_cnt=4, first_fail_idx=2.
REQ-038 A bench SHALL check: start re-pulsed at cycles 5 and 12 of a sweep -> single done, latency unchanged at 25; start held high for 60 cycles -> two done pulses, 26 cycles apart.
REQ-039 A bench SHALL check: rst asserted during DRIVE of idx=4 -> all outputs 0 immediately, no done pulse; a new start then runs a clean sweep giving 8'hB4.
REQ-040 A bench SHALL check: abc sequence monitor -> abc steps 0..7, each value held for SETTLE_CYC+1 cycles, with y_in sampled only in the last cycle.
REQ-041 A bench SHALL check, with TT_SEQ_ABORT_EN defined: abort during SAMPLE of idx=3 -> IDLE next edge, busy=0, no done, table_out[3]=0, and bits 0..2 kept.
